// File: rtl/segm7_src_arbiter.sv
// Round-robin owner of a shared 8-digit 7-seg display.
// Grants one source, writes its word once, then holds it for a dwell time.
module segm7_src_arbiter #(
   parameter int NUM_SRC      = 4,
   parameter int DWELL_CYCLES = 1000,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARSTN,
   input  logic [NUM_SRC-1:0]            REQ,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] REQ_DATA,
   output logic [NUM_SRC-1:0]            GNT,
   output logic [2:0]                    OWNER,
   output logic                          OWNER_VLD,
   output logic                          DISP_WEN,
   output logic [DATA_WIDTH-1:0]         DISP_WDATA,
   input  logic                          DISP_READY
);

   localparam int PW = $clog2(NUM_SRC);
   localparam int CW = $clog2(DWELL_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE,
      DWELL
   } state_t;

   state_t                state;
   logic [PW-1:0]         ptr;
   logic [PW-1:0]         sel;
   logic                  hit;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] words [NUM_SRC];

   // Unpack the flat request data bus into per-source words.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         words[i] = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // First requester at or after the rotation pointer, wrapping past the top.
   always_comb begin
      logic [PW:0] s;
      sel = '0;
      hit = 1'b0;
      s   = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         s = {1'b0, ptr} + (PW+1)'(i);
         if (s >= (PW+1)'(NUM_SRC)) begin
            s = s - (PW+1)'(NUM_SRC);
         end
         if (REQ[s[PW-1:0]]) begin
            sel = s[PW-1:0];
            hit = 1'b1;
         end
      end
   end

   // Arbitration FSM with registered grant, owner and display write outputs.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
      if (!S_AXI_ARSTN) begin
         state      <= IDLE;
         ptr        <= '0;
         cnt        <= '0;
         GNT        <= '0;
         OWNER      <= '0;
         OWNER_VLD  <= 1'b0;
         DISP_WEN   <= 1'b0;
         DISP_WDATA <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (hit) begin
                  GNT        <= '0;
                  GNT[sel]   <= 1'b1;
                  DISP_WDATA <= words[sel];
                  OWNER      <= 3'(sel);
                  OWNER_VLD  <= 1'b1;
                  ptr        <= (sel == PW'(NUM_SRC - 1)) ? '0 : sel + PW'(1);
                  state      <= LOAD;
               end
            end
            LOAD: begin
               GNT      <= '0;
               DISP_WEN <= 1'b1;
               state    <= WRITE;
            end
            WRITE: begin
               if (DISP_READY) begin
                  DISP_WEN <= 1'b0;
                  cnt      <= '0;
                  state    <= DWELL;
               end
            end
            DWELL: begin
               if (cnt == CW'(DWELL_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_segm7_src_arbiter.sv
// Bench for segm7_src_arbiter: timestamp-based reference model,
// per-cycle compare, directed scenarios and a randomized phase.
module tb_segm7_src_arbiter;

   localparam int N = 4;
   localparam int D = 8;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] req_data = '0;
   logic           ready = 1'b1;
   logic [N-1:0]   gnt;
   logic [2:0]     owner;
   logic           owner_vld;
   logic           wen;
   logic [W-1:0]   wdata;

   int vectors = 0;
   int miscompares = 0;
   int gq[$];

   always #5 clk = ~clk;

   segm7_src_arbiter #(
      .NUM_SRC(N),
      .DWELL_CYCLES(D),
      .DATA_WIDTH(W)
   ) dut (
      .S_AXI_ACLK(clk),
      .S_AXI_ARSTN(rst_n),
      .REQ(req),
      .REQ_DATA(req_data),
      .GNT(gnt),
      .OWNER(owner),
      .OWNER_VLD(owner_vld),
      .DISP_WEN(wen),
      .DISP_WDATA(wdata),
      .DISP_READY(ready)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: event timestamps instead of a state machine.
   longint       cyc = 0;
   longint       m_free = 0;
   longint       m_wstart = 0;
   bit           m_busy = 0;
   int           m_ptr = 0;
   logic [N-1:0] m_gnt = '0;
   logic [2:0]   m_own = '0;
   logic         m_vld = 1'b0;
   logic         m_wen = 1'b0;
   logic [W-1:0] m_wd = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_free = 0; m_busy = 0; m_ptr = 0;
         m_gnt = '0; m_own = '0; m_vld = 1'b0;
         m_wen = 1'b0; m_wd = '0;
      end else begin
         cyc++;
         m_gnt = '0;
         if (m_busy && cyc == m_wstart) begin
            m_wen = 1'b1;
         end else if (m_wen && ready) begin
            m_wen  = 1'b0;
            m_busy = 0;
            m_free = cyc + D + 1;
         end
         if (!m_busy && cyc >= m_free && req != '0) begin
            int s;
            s = -1;
            for (int i = 0; i < N; i++) begin
               int idx;
               idx = (m_ptr + i) % N;
               if (s < 0 && req[idx]) s = idx;
            end
            m_gnt[s] = 1'b1;
            m_own    = 3'(s);
            m_vld    = 1'b1;
            m_wd     = req_data[s*W +: W];
            m_ptr    = (s + 1) % N;
            m_busy   = 1;
            m_wstart = cyc + 1;
         end
      end
   end

   // Every-cycle compare against the model.
   always @(negedge clk) begin
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("owner", 32'(owner), 32'(m_own));
      check("owner_vld", 32'(owner_vld), 32'(m_vld));
      check("wen", 32'(wen), 32'(m_wen));
      check("wdata", wdata, m_wd);
   end

   // Grant log for order checks.
   always @(negedge clk) begin
      if (rst_n && gnt != '0) begin
         for (int i = 0; i < N; i++) begin
            if (gnt[i]) gq.push_back(i);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      req = '0;
      tick(2);
      rst_n = 1'b1;
      gq.delete();
   endtask

   task automatic set_data(input int i, input logic [W-1:0] v);
      req_data[i*W +: W] = v;
   endtask

   task automatic wait_grants(input int n, input int budget);
      int k;
      k = 0;
      while (gq.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      check("grant_count_reached", 32'(gq.size() >= n), 32'd1);
   endtask

   task automatic check_order(input string name, input int exp[$]);
      for (int k = 0; k < exp.size(); k++) begin
         if (k < gq.size()) check(name, 32'(gq[k]), 32'(exp[k]));
         else check(name, 32'hFFFF_FFFF, 32'(exp[k]));
      end
   endtask

   initial begin
      int gap;
      int cnt;
      int exp[$];

      tick(2);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_vld", 32'(owner_vld), 32'd0);
      check("rst_wen", 32'(wen), 32'd0);
      check("rst_wdata", wdata, 32'd0);
      rst_n = 1'b1;

      // Sole requester, latency and re-grant gap.
      set_data(0, 32'h1234_5678);
      req = 4'b0001;
      @(negedge clk);
      #2;
      check("t1_gnt", 32'(gnt), 32'h1);
      check("t1_wen0", 32'(wen), 32'h0);
      check("t1_vld", 32'(owner_vld), 32'h1);
      @(negedge clk);
      #2;
      check("t1_wen", 32'(wen), 32'h1);
      check("t1_wdata", wdata, 32'h1234_5678);
      gap = 0;
      cnt = 0;
      while (gnt == '0 && cnt < 100) begin
         @(negedge clk);
         #2;
         gap++;
         cnt++;
      end
      check("t1_regrant_gap_ge8", 32'(gap >= 8), 32'd1);
      check("t1_regrant_owner", 32'(owner), 32'd0);

      // Full rotation.
      do_reset();
      for (int i = 0; i < N; i++) set_data(i, 32'hAAAA_0000 | 32'(i));
      req = 4'b1111;
      wait_grants(5, 200);
      req = '0;
      exp = '{0, 1, 2, 3, 0};
      check_order("t2_order", exp);
      tick(15);

      // Sparse requesters after serving source 1.
      do_reset();
      req = 4'b0010;
      wait_grants(1, 50);
      req = 4'b1010;
      wait_grants(4, 200);
      req = '0;
      exp = '{1, 3, 1, 3};
      check_order("t3_order", exp);
      tick(15);

      // Stalled sink.
      set_data(0, 32'h0BAD_F00D);
      req = 4'b0001;
      cnt = 0;
      while (!wen && cnt < 50) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      req = '0;
      ready = 1'b0;
      cnt = 1;
      repeat (5) begin
         @(negedge clk);
         cnt += int'(wen);
         check("t4_wdata_stable", wdata, 32'h0BAD_F00D);
         #1;
      end
      ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         cnt += int'(wen);
         #1;
      end
      check("t4_wen_cycles", 32'(cnt), 32'd6);
      tick(12);

      // Async reset mid-dwell.
      set_data(2, 32'h2222_2222);
      gq.delete();
      req = 4'b0100;
      wait_grants(1, 50);
      req = '0;
      tick(4);
      check("t5_owner_pre", 32'(owner), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_gnt", 32'(gnt), 32'd0);
      check("t5_owner", 32'(owner), 32'd0);
      check("t5_vld", 32'(owner_vld), 32'd0);
      check("t5_wen", 32'(wen), 32'd0);
      check("t5_wdata", wdata, 32'd0);
      tick(2);
      rst_n = 1'b1;
      gq.delete();
      req = 4'b0101;
      wait_grants(1, 50);
      req = '0;
      exp = '{0};
      check_order("t5_first", exp);
      tick(15);

      // Idle hold.
      set_data(1, 32'hCAFE_0001);
      req = 4'b0010;
      gq.delete();
      wait_grants(1, 50);
      req = '0;
      tick(20);
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (gnt != '0 || wen) cnt++;
         #1;
      end
      check("t6_activity", 32'(cnt), 32'd0);
      check("t6_vld", 32'(owner_vld), 32'd1);
      check("t6_owner", 32'(owner), 32'd1);
      check("t6_wdata", wdata, 32'hCAFE_0001);

      // Random traffic.
      do_reset();
      for (int k = 0; k < 400; k++) begin
         req   = 4'($urandom_range(0, 15));
         ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) set_data(i, $urandom);
         tick(1);
      end
      ready = 1'b1;
      req = '0;
      tick(20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
